dds_ftw_calc: RTL

//  Converts a frequency in Hz into the 48-bit AD9854 frequency tuning word.

---
 rtl/dds_ftw_calc_if.sv | 15 +
 rtl/dds_ftw_calc.sv | 98 +++++++++
 2 files changed

// File: rtl/dds_ftw_calc_if.sv
// Request/result bundle between the frequency source and dds_ftw_calc.
// master drives the request side; slave is the converter.
interface dds_ftw_calc_if;
  logic        start;
  logic [31:0] freq_hz;
  logic        busy;
  logic        done;
  logic        sat;
  logic [47:0] ftw;

  modport master (output start, output freq_hz,
                  input  busy, input done, input sat, input ftw);
  modport slave  (input  start, input freq_hz,
                  output busy, output done, output sat, output ftw);
endinterface

// File: rtl/dds_ftw_calc.sv
// Hz -> 48-bit AD9854 FTW via serial shift-add multiply by K_Q, one bit per clk.
// Define FTW_ROUND_EN to round half up at the fractional cut instead of truncating.
module dds_ftw_calc #(
  parameter logic [39:0] K_Q       = 40'd61489146912,
  parameter int unsigned FRAC_BITS = 16,
  parameter logic [31:0] FREQ_MAX  = 32'd150000000
) (
  input logic            clk,
  input logic            rst_n,
  dds_ftw_calc_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] op_q;
  logic [71:0] acc_q;
  logic [4:0]  cnt_q;
  logic        sat_n_q;
  logic        busy_q;
  logic        done_q;
  logic        sat_q;
  logic [47:0] ftw_q;
  logic [71:0] acc_fin;
  logic [71:0] k_ext;

  assign k_ext = 72'(K_Q);

`ifdef FTW_ROUND_EN
  localparam logic [71:0] RND = 72'(1) << (FRAC_BITS - 1);
  assign acc_fin = acc_q + RND;
`else
  assign acc_fin = acc_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = MUL;
      MUL:     if (cnt_q == 5'd31) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_n_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      ftw_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            // Clamp at acceptance so the product always fits the 48-bit slice
            op_q    <= (bus.freq_hz > FREQ_MAX) ? FREQ_MAX : bus.freq_hz;
            sat_n_q <= (bus.freq_hz > FREQ_MAX);
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        MUL: begin
          if (op_q[0]) acc_q <= acc_q + (k_ext << cnt_q);
          op_q  <= op_q >> 1;
          cnt_q <= cnt_q + 5'd1;
        end
        DONE: begin
          ftw_q  <= acc_fin[FRAC_BITS +: 48];
          sat_q  <= sat_n_q;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sat  = sat_q;
  assign bus.ftw  = ftw_q;

endmodule
